// File: rtl/pattern_det.sv
// pattern_det: programmable serial bit-pattern detector with registered match pulse.
// Define PATTERN_DET_COUNT_EN to add the saturating match_count register.
module pattern_det #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               detected,
    output logic               busy,
    output logic [CNT_W-1:0]   match_count
);
    typedef enum logic [1:0] {UNCFG, FILL, HUNT} state_t;
    state_t state, state_n;
    logic [MAX_LEN-1:0] hist, hist_n, hist_sh, pat_r, mask;
    logic [LEN_W-1:0] fill, fill_n, len_r;
    logic [LEN_W:0] fill_inc;
    logic overlap_r, detected_n, match;
    assign hist_sh  = {hist[MAX_LEN-2:0], din};
    assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
    // shifting past MAX_LEN yields zero, so the mask saturates to all ones
    assign mask     = ~({MAX_LEN{1'b1}} << len_r);
    assign match    = fill_inc >= {1'b0, len_r} && len_r >= LEN_W'(2) &&
                      ((hist_sh ^ pat_r) & mask) == '0;
    assign busy     = state != UNCFG && fill != '0;
    always_comb begin
        state_n    = state;
        hist_n     = hist;
        fill_n     = fill;
        detected_n = 1'b0;
        if (cfg_we) begin
            state_n = FILL;
            hist_n  = '0;
            fill_n  = '0;
        end else if (din_valid && state != UNCFG) begin
            hist_n     = hist_sh;
            fill_n     = fill_inc > (LEN_W + 1)'(MAX_LEN) ? LEN_W'(MAX_LEN) : fill_inc[LEN_W-1:0];
            detected_n = match;
            if (match && !overlap_r) begin
                hist_n = '0;
                fill_n = '0;
            end
            state_n = fill_n >= len_r ? HUNT : FILL;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNCFG;
            hist     <= '0;
            fill     <= '0;
            detected <= 1'b0;
        end else begin
            state    <= state_n;
            hist     <= hist_n;
            fill     <= fill_n;
            detected <= detected_n;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r     <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
        end else if (cfg_we) begin
            pat_r     <= cfg_pattern;
            len_r     <= cfg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
            overlap_r <= cfg_overlap;
        end
    end
`ifdef PATTERN_DET_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_count <= '0;
        else if (cfg_we)
            match_count <= '0;
        else if (detected_n && match_count != '1)
            match_count <= match_count + CNT_W'(1);
    end
`else
    assign match_count = '0;
`endif
endmodule

// File: tb/tb_pattern_det.sv
// tb_pattern_det: directed self-checking bench for pattern_det (MAX_LEN=8).
module tb_pattern_det;
    localparam int ML = 8;
    localparam int LW = 4;
    localparam int CW = 16;
    logic clk = 0, rst_n = 0, cfg_we = 0, cfg_overlap = 0, din_valid = 0, din = 0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic detected, busy;
    logic [CW-1:0] match_count;
    int n_cmp = 0, n_err = 0;

    pattern_det #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
        .din(din), .detected(detected), .busy(busy), .match_count(match_count)
    );

    always #5 clk = ~clk;

    function automatic int ec(input int n);
`ifdef PATTERN_DET_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [ML-1:0] pat, input logic [LW-1:0] len, input logic ov);
        @(negedge clk);
        cfg_we = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic send(input logic d);
        @(negedge clk);
        din_valid = 1; din = d;
        @(posedge clk); #1;
        din_valid = 0;
    endtask

    // bits/exp are given first-received bit in the MSB position of the n-bit field
    task automatic send_seq(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
            check($sformatf("%s_b%0d", tag, n - i), {31'b0, detected}, {31'b0, exp[i]});
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_gap%0d", tag, i), {31'b0, detected}, 32'd0);
        end
    endtask

    initial begin
        #12;
        check("rst_det", {31'b0, detected}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_cnt", {16'b0, match_count}, 0);
        @(negedge clk); rst_n = 1;

        send_seq("uncfg", 3, 16'b101, 16'b000);
        check("uncfg_busy", {31'b0, busy}, 0);

        cfg(8'b101, 3, 1);
        send_seq("ov1", 7, 16'b1010101, 16'b0010101);
        check("ov1_cnt", {16'b0, match_count}, ec(3));
        idle("ov1", 1);

        cfg(8'b101, 3, 0);
        send_seq("ov0a", 3, 16'b101, 16'b001);
        check("ov0_busy_after_match", {31'b0, busy}, 0);
        send_seq("ov0b", 4, 16'b0101, 16'b0001);
        check("ov0_busy_end", {31'b0, busy}, 0);
        check("ov0_cnt", {16'b0, match_count}, ec(2));

        cfg(8'b1100_1010, 8, 0);
        send_seq("len8a", 4, 16'b1100, 16'b0000);
        check("len8_busy_gap", {31'b0, busy}, 1);
        idle("len8", 3);
        send_seq("len8b", 4, 16'b1010, 16'b0001);
        check("len8_cnt", {16'b0, match_count}, ec(1));

        cfg(8'h00, 0, 1);
        send_seq("len0", 4, 16'b0000, 16'b0000);
        cfg(8'h01, 1, 1);
        send_seq("len1", 3, 16'b111, 16'b000);
        check("len1_busy", {31'b0, busy}, 1);
        check("len1_cnt", {16'b0, match_count}, ec(0));

        cfg(8'b1100_1010, 15, 0);
        send_seq("clamp", 8, 16'b1100_1010, 16'b0000_0001);
        check("clamp_cnt", {16'b0, match_count}, ec(1));

        cfg(8'b101, 3, 1);
        send_seq("coll_a", 2, 16'b10, 16'b00);
        @(negedge clk);
        cfg_we = 1; cfg_pattern = 8'b101; cfg_len = 3; cfg_overlap = 1;
        din_valid = 1; din = 1;
        @(posedge clk); #1;
        cfg_we = 0; din_valid = 0;
        check("coll_det", {31'b0, detected}, 0);
        check("coll_busy", {31'b0, busy}, 0);
        send_seq("coll_b", 3, 16'b101, 16'b001);
        check("coll_cnt", {16'b0, match_count}, ec(1));

        cfg(8'b101, 3, 1);
        send_seq("rst_a", 3, 16'b101, 16'b001);
        @(negedge clk); rst_n = 0; #1;
        check("mid_rst_det", {31'b0, detected}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_cnt", {16'b0, match_count}, 0);
        @(negedge clk); rst_n = 1;
        send_seq("rst_b", 3, 16'b101, 16'b000);
        check("rst_b_busy", {31'b0, busy}, 0);
        cfg(8'b101, 3, 1);
        send_seq("rst_c", 3, 16'b101, 16'b001);
        check("rst_c_cnt", {16'b0, match_count}, ec(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
